fifo_read_ctrl: RTL

//  Read-side controller for the synchronous FIFO: pops words through the FIFO rd/empty/d_out port.
//  Re-presents them downstream as a valid/ready stream.

---
 rtl/fifo_read_ctrl_if.sv | 51 +++++
 rtl/fifo_read_ctrl.sv | 101 ++++++++++
 2 files changed

// File: rtl/fifo_read_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_read_ctrl_if
//   Bundles the FIFO read port and the downstream valid/ready stream used by
//   fifo_read_ctrl. The controller connects through the master modport; the
//   FIFO/consumer side (or a testbench) connects through the slave modport.
//
//   Signals
//     fifo_empty  FIFO empty flag                        (slave -> master)
//     fifo_dout   FIFO read data, 1 clk after fifo_rd    (slave -> master)
//     fifo_rd     FIFO read strobe                       (master -> slave)
//     m_valid     downstream data valid                  (master -> slave)
//     m_ready     downstream ready                       (slave -> master)
//     m_data      downstream data, oldest buffered word  (master -> slave)
//     rd_count    words delivered downstream, wrapping   (master -> slave)
//     busy        word in flight or buffer non-empty     (master -> slave)
// -----------------------------------------------------------------------------
interface fifo_read_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_rd;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [CNT_W-1:0]  rd_count;
    logic              busy;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  m_ready,
        output fifo_rd,
        output m_valid,
        output m_data,
        output rd_count,
        output busy
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        output m_ready,
        input  fifo_rd,
        input  m_valid,
        input  m_data,
        input  rd_count,
        input  busy
    );
endinterface

// File: rtl/fifo_read_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_read_ctrl
//   Read-side controller for a synchronous FIFO whose read data is registered
//   (valid one clock after an accepted read). Words are popped from the FIFO
//   and re-presented downstream as a valid/ready stream. A 2-entry skid buffer
//   absorbs the one-cycle read latency so that one word per clock is sustained
//   with no loss or duplication.
//
//   Parameters
//     DATA_W  width of FIFO data and m_data
//     CNT_W   width of the delivered-word counter
//
//   Ports
//     clk     system clock, all logic on posedge
//     rst     synchronous reset, active-low (0 = reset)
//     en      1 = new FIFO reads allowed; 0 = stop reading, drain the buffer
//     bus     fifo_read_ctrl_if.master: FIFO read port + downstream stream
// -----------------------------------------------------------------------------
module fifo_read_ctrl #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    fifo_read_ctrl_if.master  bus
);

    // Skid buffer state: r_buf0 is always the head (oldest word).
    logic [1:0]        r_occ;
    logic              r_inflight;
    logic [DATA_W-1:0] r_buf0;
    logic [DATA_W-1:0] r_buf1;
    logic [CNT_W-1:0]  r_count;

    logic              w_pop;
    logic              w_rd;
    logic [2:0]        w_level;
    logic [1:0]        w_slot;
    logic              w_wr_head;

    // Read decision looks at the occupancy the buffer will have after this
    // cycle's capture and pop; a read issued now lands one cycle later, so it
    // must find a free slot then. This makes m_ready -> fifo_rd combinational.
    always_comb begin
        w_pop     = (r_occ != 2'd0) && bus.m_ready;
        w_level   = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
        w_rd      = rst && en && !bus.fifo_empty && (w_level < 3'd2);
        // Slot the arriving word goes to, counted after the head has advanced.
        w_slot    = r_occ - {1'b0, w_pop};
        w_wr_head = (w_slot == 2'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_occ      <= '0;
            r_inflight <= 1'b0;
            r_buf0     <= '0;
            r_buf1     <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= w_rd;
            r_occ      <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};

            if (w_pop) begin
                r_buf0  <= r_buf1;
                r_count <= r_count + CNT_W'(1);
            end

            // Capture overrides the shift above when it targets the head
            // (buffer empty, or single entry being popped this cycle).
            if (r_inflight) begin
                if (w_wr_head) begin
                    r_buf0 <= bus.fifo_dout;
                end else begin
                    r_buf1 <= bus.fifo_dout;
                end
            end
        end
    end

    assign bus.fifo_rd  = w_rd;
    assign bus.m_valid  = (r_occ != 2'd0);
    assign bus.m_data   = r_buf0;
    assign bus.rd_count = r_count;
    assign bus.busy     = r_inflight || (r_occ != 2'd0);

    // Safety properties of the read/skid-buffer protocol.
    a_no_rd_on_empty : assert property (@(posedge clk)
        !(bus.fifo_rd && bus.fifo_empty));

    a_occ_range : assert property (@(posedge clk) disable iff (!rst)
        (r_occ <= 2'd2) && (w_level <= 3'd2));

    a_data_stable : assert property (@(posedge clk) disable iff (!rst)
        (bus.m_valid && !bus.m_ready) |=> $stable(bus.m_data));

    a_no_pop_invalid : assert property (@(posedge clk) disable iff (!rst)
        !bus.m_valid |=> $stable(bus.rd_count));

endmodule
